// File: rtl/spio_hss_multiplexer_chan_scheduler.sv
// Transmit-side channel scheduler for the HSS multiplexer: per-channel FIFOs,
// round-robin / fixed-priority arbitration gated by remote flow control and frame credit.
module spio_hss_multiplexer_chan_scheduler #(
  parameter int NUM_CHANS  = 8,
  parameter int PKT_BITS   = 72,
  parameter int FIFO_DEPTH = 4,
  parameter int CRDT_BITS  = 8,
  parameter int CRDT_INIT  = 32,
  parameter int CHAN_BITS  = $clog2(NUM_CHANS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CHANS*PKT_BITS-1:0] pkt_data,
  input  logic [NUM_CHANS-1:0]          pkt_vld,
  output logic [NUM_CHANS-1:0]          pkt_rdy,
  input  logic [NUM_CHANS-1:0]          cfc_rem,
  input  logic                          mode_prio,
  input  logic                          crdt_load,
  input  logic [CRDT_BITS-1:0]          crdt_val,
  input  logic                          crdt_ret,
  output logic [PKT_BITS-1:0]           out_data,
  output logic [CHAN_BITS-1:0]          out_chan,
  output logic                          out_vld,
  input  logic                          out_rdy,
  output logic                          ooc_vld,
  output logic [NUM_CHANS-1:0]          reg_empt,
  output logic [NUM_CHANS-1:0]          reg_full,
  output logic [CRDT_BITS-1:0]          reg_crdt
);

  localparam int PTR_BITS = $clog2(FIFO_DEPTH);
  localparam int CNT_BITS = PTR_BITS + 1;
  localparam logic [CNT_BITS-1:0] FULL_CNT = CNT_BITS'(FIFO_DEPTH);

  logic [PKT_BITS-1:0]  r_mem  [NUM_CHANS][FIFO_DEPTH];
  logic [PTR_BITS-1:0]  r_wptr [NUM_CHANS];
  logic [PTR_BITS-1:0]  r_rptr [NUM_CHANS];
  logic [CNT_BITS-1:0]  r_cnt  [NUM_CHANS];

  logic [PKT_BITS-1:0]  r_out_data;
  logic [CHAN_BITS-1:0] r_out_chan;
  logic                 r_out_vld;
  logic [CHAN_BITS-1:0] r_ptr;
  logic [CRDT_BITS-1:0] r_crdt;
  logic                 r_ooc_cond;
  logic                 r_ooc;

  logic [NUM_CHANS-1:0] w_empty, w_full, w_push, w_pop, w_pend, w_elig;
  logic                 w_crdt_ok, w_gnt_any, w_load, w_ooc_cond;
  logic [CHAN_BITS-1:0] w_gnt, w_idx;
  logic [PKT_BITS-1:0]  w_head;

  // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    w_empty = '0;
    w_full  = '0;
    for (int i = 0; i < NUM_CHANS; i++) begin
      w_empty[i] = (r_cnt[i] == '0);
      w_full[i]  = (r_cnt[i] == FULL_CNT);
    end
  end

  // Ready depends on registered occupancy only, never on pkt_vld.
  assign pkt_rdy    = ~w_full;
  assign w_push     = pkt_vld & ~w_full;
  assign w_crdt_ok  = (r_crdt != '0);
  assign w_pend     = ~w_empty & ~cfc_rem;
  assign w_elig     = w_pend & {NUM_CHANS{w_crdt_ok}};
  assign w_ooc_cond = !w_crdt_ok && (|w_pend);

  // Round-robin scans from ptr+1 with wrap; fixed priority scans from index 0.
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt     = '0;
    w_idx     = '0;
    for (int k = 0; k < NUM_CHANS; k++) begin
      if (mode_prio) w_idx = CHAN_BITS'(k);
      else           w_idx = CHAN_BITS'((int'(r_ptr) + 1 + k) % NUM_CHANS);
      if (!w_gnt_any && w_elig[w_idx]) begin
        w_gnt_any = 1'b1;
        w_gnt     = w_idx;
      end
    end
  end

  assign w_load = (!r_out_vld || out_rdy) && w_gnt_any;
  assign w_head = r_mem[w_gnt][r_rptr[w_gnt]];

  always_comb begin
    w_pop = '0;
    if (w_load) w_pop[w_gnt] = 1'b1;
  end

  // NOTE: packet storage has no reset; occupancy gates every read, so stale entries are never observed.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CHANS; i++)
      if (w_push[i]) r_mem[i][r_wptr[i]] <= pkt_data[i*PKT_BITS +: PKT_BITS];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_CHANS; i++) begin
        r_wptr[i] <= '0;
        r_rptr[i] <= '0;
        r_cnt[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CHANS; i++) begin
        if (w_push[i]) r_wptr[i] <= r_wptr[i] + 1'b1;
        if (w_pop[i])  r_rptr[i] <= r_rptr[i] + 1'b1;
        if (w_push[i] && !w_pop[i])      r_cnt[i] <= r_cnt[i] + 1'b1;
        else if (!w_push[i] && w_pop[i]) r_cnt[i] <= r_cnt[i] - 1'b1;
      end
    end
  end

  // Output register holds while stalled; drops valid when a transfer finds nothing eligible.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_vld  <= 1'b0;
      r_out_data <= '0;
      r_out_chan <= '0;
      r_ptr      <= CHAN_BITS'(NUM_CHANS - 1);
    end else if (w_load) begin
      r_out_vld  <= 1'b1;
      r_out_data <= w_head;
      r_out_chan <= w_gnt;
      r_ptr      <= w_gnt;
    end else if (out_rdy) begin
      r_out_vld  <= 1'b0;
    end
  end

  // A load overrides grant/return; grant and return together cancel.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                        r_crdt <= CRDT_BITS'(CRDT_INIT);
    else if (crdt_load)                              r_crdt <= crdt_val;
    else if (w_load && !crdt_ret)                    r_crdt <= r_crdt - 1'b1;
    else if (!w_load && crdt_ret && (r_crdt != '1))  r_crdt <= r_crdt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ooc_cond <= 1'b0;
      r_ooc      <= 1'b0;
    end else begin
      r_ooc_cond <= w_ooc_cond;
      r_ooc      <= w_ooc_cond && !r_ooc_cond;
    end
  end

  assign out_data = r_out_data;
  assign out_chan = r_out_chan;
  assign out_vld  = r_out_vld;
  assign ooc_vld  = r_ooc;
  assign reg_empt = w_empty;
  assign reg_full = w_full;
  assign reg_crdt = r_crdt;

endmodule

// File: tb/tb_spio_hss_multiplexer_chan_scheduler.sv
// Directed bench for the channel scheduler: reset, round-robin, priority with
// backpressure, FIFO wrap, credit handling, flow control and mid-traffic reset.
module tb_spio_hss_multiplexer_chan_scheduler;

  logic          clk = 1'b0;
  logic          rst;
  logic [575:0]  pkt_data;
  logic [7:0]    pkt_vld, pkt_rdy, cfc_rem;
  logic          mode_prio, crdt_load, crdt_ret;
  logic [7:0]    crdt_val;
  logic [71:0]   out_data;
  logic [2:0]    out_chan;
  logic          out_vld, out_rdy, ooc_vld;
  logic [7:0]    reg_empt, reg_full, reg_crdt;

  int errors = 0;
  int checks = 0;

  spio_hss_multiplexer_chan_scheduler #(
    .NUM_CHANS(8), .PKT_BITS(72), .FIFO_DEPTH(4), .CRDT_BITS(8), .CRDT_INIT(32)
  ) dut (
    .clk(clk), .rst(rst), .pkt_data(pkt_data), .pkt_vld(pkt_vld), .pkt_rdy(pkt_rdy),
    .cfc_rem(cfc_rem), .mode_prio(mode_prio), .crdt_load(crdt_load), .crdt_val(crdt_val),
    .crdt_ret(crdt_ret), .out_data(out_data), .out_chan(out_chan), .out_vld(out_vld),
    .out_rdy(out_rdy), .ooc_vld(ooc_vld), .reg_empt(reg_empt), .reg_full(reg_full),
    .reg_crdt(reg_crdt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [71:0] mk(input int ch, input int seq);
    return {8'(ch), 56'h5A5A_C3C3_0F0F_96, 8'(seq)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_credit(input logic [7:0] v);
    crdt_load = 1'b1; crdt_val = v;
    tick();
    crdt_load = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3 rst = 1'b0;
    #2;
    checks++; if (out_vld !== 1'b0)   begin errors++; $display("FAIL reset_out_vld: got %0b want 0", out_vld); end
    checks++; if (out_data !== '0)    begin errors++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    checks++; if (out_chan !== 3'd0)  begin errors++; $display("FAIL reset_out_chan: got %0d want 0", out_chan); end
    checks++; if (ooc_vld !== 1'b0)   begin errors++; $display("FAIL reset_ooc: got %0b want 0", ooc_vld); end
    checks++; if (reg_empt !== 8'hFF) begin errors++; $display("FAIL reset_empt: got %h want ff", reg_empt); end
    checks++; if (reg_full !== 8'h00) begin errors++; $display("FAIL reset_full: got %h want 00", reg_full); end
    checks++; if (pkt_rdy !== 8'hFF)  begin errors++; $display("FAIL reset_rdy: got %h want ff", pkt_rdy); end
    checks++; if (reg_crdt !== 8'd32) begin errors++; $display("FAIL reset_crdt: got %0d want 32", reg_crdt); end
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    tick();
  endtask

  task automatic test_round_robin();
    int chs[3] = '{0, 3, 7};
    mode_prio = 1'b0; out_rdy = 1'b1;
    for (int s = 0; s < 2; s++) begin
      foreach (chs[j]) begin
        pkt_vld[chs[j]] = 1'b1;
        pkt_data[chs[j]*72 +: 72] = mk(chs[j], s);
      end
      tick();
      if (s == 0) begin
        checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL rr_latency_early: out_vld got %0b want 0", out_vld); end
      end
    end
    pkt_vld = '0;
    for (int n = 0; n < 6; n++) begin
      checks++;
      if (out_vld !== 1'b1 || out_chan !== 3'(chs[n%3]) || out_data !== mk(chs[n%3], n/3)) begin
        errors++;
        $display("FAIL rr_seq%0d: got vld=%0b chan=%0d data=%h want chan=%0d data=%h",
                 n, out_vld, out_chan, out_data, chs[n%3], mk(chs[n%3], n/3));
      end
      tick();
    end
    checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL rr_idle: out_vld got %0b want 0", out_vld); end
  endtask

  task automatic test_prio_backpressure();
    int exp_ch[4]  = '{2, 2, 5, 5};
    int exp_seq[4] = '{0, 1, 0, 1};
    mode_prio = 1'b1; out_rdy = 1'b0;
    for (int s = 0; s < 2; s++) begin
      pkt_vld[2] = 1'b1; pkt_data[2*72 +: 72] = mk(2, s);
      pkt_vld[5] = 1'b1; pkt_data[5*72 +: 72] = mk(5, s);
      tick();
    end
    pkt_vld = '0;
    for (int h = 0; h < 3; h++) begin
      checks++;
      if (out_vld !== 1'b1 || out_chan !== 3'd2 || out_data !== mk(2, 0)) begin
        errors++;
        $display("FAIL prio_hold%0d: got vld=%0b chan=%0d data=%h want chan=2 data=%h",
                 h, out_vld, out_chan, out_data, mk(2, 0));
      end
      cfc_rem = (h == 1) ? 8'hFF : 8'h00;
      tick();
    end
    out_rdy = 1'b1;
    for (int n = 0; n < 4; n++) begin
      checks++;
      if (out_vld !== 1'b1 || out_chan !== 3'(exp_ch[n]) || out_data !== mk(exp_ch[n], exp_seq[n])) begin
        errors++;
        $display("FAIL prio_drain%0d: got vld=%0b chan=%0d data=%h want chan=%0d data=%h",
                 n, out_vld, out_chan, out_data, exp_ch[n], mk(exp_ch[n], exp_seq[n]));
      end
      tick();
    end
    checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL prio_idle: out_vld got %0b want 0", out_vld); end
    mode_prio = 1'b0;
  endtask

  task automatic test_fifo_wrap();
    int next_in = 4;
    int next_out = 0;
    out_rdy = 1'b0; cfc_rem = 8'h02;
    for (int s = 0; s < 4; s++) begin
      pkt_vld[1] = 1'b1; pkt_data[72 +: 72] = mk(1, s);
      tick();
    end
    pkt_data[72 +: 72] = mk(1, 99);
    checks++; if (reg_full[1] !== 1'b1) begin errors++; $display("FAIL fifo_full: reg_full[1] got %0b want 1", reg_full[1]); end
    checks++; if (pkt_rdy[1] !== 1'b0)  begin errors++; $display("FAIL fifo_rdy: pkt_rdy[1] got %0b want 0", pkt_rdy[1]); end
    checks++; if (out_vld !== 1'b0)     begin errors++; $display("FAIL fifo_stopped: out_vld got %0b want 0", out_vld); end
    tick();
    pkt_vld[1] = 1'b0;
    checks++; if (reg_full !== 8'h02)   begin errors++; $display("FAIL fifo_full_hold: reg_full got %h want 02", reg_full); end
    cfc_rem = 8'h00; out_rdy = 1'b1;
    for (int cyc = 0; cyc < 60 && next_out < 14; cyc++) begin
      bit acc;
      pkt_vld[1] = (next_in < 14);
      pkt_data[72 +: 72] = mk(1, next_in);
      acc = pkt_vld[1] && pkt_rdy[1];
      if (out_vld) begin
        checks++;
        if (out_chan !== 3'd1 || out_data !== mk(1, next_out)) begin
          errors++;
          $display("FAIL fifo_order%0d: got chan=%0d data=%h want chan=1 data=%h",
                   next_out, out_chan, out_data, mk(1, next_out));
        end
        next_out++;
      end
      tick();
      if (acc) next_in++;
    end
    pkt_vld = '0;
    checks++; if (next_out != 14) begin errors++; $display("FAIL fifo_count: got %0d packets want 14", next_out); end
  endtask

  task automatic test_credit();
    int n_out = 0;
    int ooc_cnt = 0;
    out_rdy = 1'b1;
    load_credit(8'd2);
    checks++; if (reg_crdt !== 8'd2) begin errors++; $display("FAIL crdt_load: got %0d want 2", reg_crdt); end
    for (int k = 0; k < 10; k++) begin
      pkt_vld[0] = (k < 4);
      pkt_data[0 +: 72] = mk(0, k);
      if (out_vld) begin
        checks++;
        if (out_chan !== 3'd0 || out_data !== mk(0, n_out)) begin
          errors++; $display("FAIL crdt_pkt%0d: got chan=%0d data=%h want data=%h", n_out, out_chan, out_data, mk(0, n_out));
        end
        n_out++;
      end
      if (ooc_vld) ooc_cnt++;
      tick();
    end
    pkt_vld = '0;
    checks++; if (n_out != 2)        begin errors++; $display("FAIL crdt_grants: got %0d want 2", n_out); end
    checks++; if (reg_crdt !== 8'd0) begin errors++; $display("FAIL crdt_zero: got %0d want 0", reg_crdt); end
    checks++; if (ooc_cnt != 1)      begin errors++; $display("FAIL crdt_ooc: got %0d pulses want 1", ooc_cnt); end
    crdt_ret = 1'b1;
    tick();
    crdt_ret = 1'b0;
    ooc_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      if (out_vld) begin
        checks++;
        if (out_data !== mk(0, n_out)) begin
          errors++; $display("FAIL crdt_ret_pkt: got data=%h want %h", out_data, mk(0, n_out));
        end
        n_out++;
      end
      if (ooc_vld) ooc_cnt++;
      tick();
    end
    checks++; if (n_out != 3)        begin errors++; $display("FAIL crdt_ret_grants: got %0d want 3", n_out); end
    checks++; if (ooc_cnt != 1)      begin errors++; $display("FAIL crdt_ooc_rearm: got %0d pulses want 1", ooc_cnt); end
    checks++; if (reg_crdt !== 8'd0) begin errors++; $display("FAIL crdt_ret_zero: got %0d want 0", reg_crdt); end
    crdt_ret = 1'b1;
    tick();
    tick();
    crdt_ret = 1'b0;
    checks++; if (reg_crdt !== 8'd1) begin errors++; $display("FAIL crdt_gnt_ret: got %0d want 1", reg_crdt); end
    checks++;
    if (out_vld !== 1'b1 || out_data !== mk(0, 3)) begin
      errors++; $display("FAIL crdt_last_pkt: got vld=%0b data=%h want data=%h", out_vld, out_data, mk(0, 3));
    end
    tick();
    checks++; if (out_vld !== 1'b0 || reg_empt[0] !== 1'b1) begin
      errors++; $display("FAIL crdt_drained: got vld=%0b empt0=%0b want 0/1", out_vld, reg_empt[0]);
    end
  endtask

  task automatic test_flow_control();
    int n6 = 0;
    int n_any = 0;
    int ooc_cnt = 0;
    bit found = 1'b0;
    out_rdy = 1'b1;
    load_credit(8'd32);
    cfc_rem = 8'h10;
    pkt_vld[4] = 1'b1; pkt_data[4*72 +: 72] = mk(4, 0);
    pkt_vld[6] = 1'b1; pkt_data[6*72 +: 72] = mk(6, 0);
    tick();
    pkt_vld = '0;
    for (int k = 0; k < 5; k++) begin
      if (out_vld) begin
        checks++;
        if (out_chan !== 3'd6 || out_data !== mk(6, 0)) begin
          errors++; $display("FAIL cfc_stopped_chan: got chan=%0d data=%h want chan=6", out_chan, out_data);
        end
        n6++;
      end
      tick();
    end
    checks++; if (n6 != 1)             begin errors++; $display("FAIL cfc_ch6_count: got %0d want 1", n6); end
    checks++; if (reg_empt[4] !== 1'b0) begin errors++; $display("FAIL cfc_ch4_held: empt4 got %0b want 0", reg_empt[4]); end
    cfc_rem = 8'h00;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (!found && out_vld === 1'b1 && out_chan === 3'd4 && out_data === mk(4, 0)) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL cfc_release: channel 4 got no grant within 2 cycles, want grant"); end
    cfc_rem = 8'h10;
    crdt_load = 1'b1; crdt_val = 8'd0;
    pkt_vld[4] = 1'b1; pkt_data[4*72 +: 72] = mk(4, 1);
    tick();
    crdt_load = 1'b0; pkt_vld = '0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (ooc_vld) ooc_cnt++;
      if (out_vld) n_any++;
    end
    checks++; if (ooc_cnt != 0) begin errors++; $display("FAIL cfc_no_ooc: got %0d pulses want 0", ooc_cnt); end
    checks++; if (n_any != 0)   begin errors++; $display("FAIL cfc_no_grant: got %0d outputs want 0", n_any); end
    cfc_rem = 8'h00;
    ooc_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (ooc_vld) ooc_cnt++;
    end
    checks++; if (ooc_cnt != 1) begin errors++; $display("FAIL cfc_ooc_on_release: got %0d pulses want 1", ooc_cnt); end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    out_rdy = 1'b0;
    load_credit(8'd32);
    for (int s = 0; s < 2; s++) begin
      pkt_vld[0] = 1'b1; pkt_data[0 +: 72]    = mk(0, 20 + s);
      pkt_vld[2] = 1'b1; pkt_data[2*72 +: 72] = mk(2, 20 + s);
      tick();
    end
    pkt_vld = '0;
    tick();
    checks++; if (out_vld !== 1'b1) begin errors++; $display("FAIL rstmid_pre: out_vld got %0b want 1", out_vld); end
    #2 rst = 1'b0;
    #1;
    checks++; if (out_vld !== 1'b0 || out_data !== '0 || out_chan !== 3'd0) begin
      errors++; $display("FAIL rstmid_out: got vld=%0b chan=%0d data=%h want all 0", out_vld, out_chan, out_data);
    end
    checks++; if (reg_empt !== 8'hFF || reg_full !== 8'h00 || pkt_rdy !== 8'hFF) begin
      errors++; $display("FAIL rstmid_fifo: got empt=%h full=%h rdy=%h want ff/00/ff", reg_empt, reg_full, pkt_rdy);
    end
    checks++; if (reg_crdt !== 8'd32 || ooc_vld !== 1'b0) begin
      errors++; $display("FAIL rstmid_crdt: got crdt=%0d ooc=%0b want 32/0", reg_crdt, ooc_vld);
    end
    @(negedge clk) rst = 1'b1;
    out_rdy = 1'b1;
    tick();
    for (int k = 0; k < 6; k++) begin
      if (out_vld) n++;
      tick();
    end
    checks++; if (n != 0)             begin errors++; $display("FAIL rstmid_discard: got %0d outputs want 0", n); end
    checks++; if (reg_empt !== 8'hFF) begin errors++; $display("FAIL rstmid_empty: got %h want ff", reg_empt); end
  endtask

  initial begin
    rst = 1'b1; pkt_data = '0; pkt_vld = '0; cfc_rem = '0; mode_prio = 1'b0;
    crdt_load = 1'b0; crdt_val = '0; crdt_ret = 1'b0; out_rdy = 1'b0;
    test_reset();
    test_round_robin();
    test_prio_backpressure();
    test_fifo_wrap();
    test_credit();
    test_flow_control();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
